// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with configurable frame format and an input FIFO.
// Frames are start, DATA_BITS LSB first, optional parity, then STOP_BITS stop bits; queued words go out back-to-back.
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          tx
);

  localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LAST_CYC  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;

  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (cyc_q == LAST_CYC);
  assign tx_ready   = (count_q != CNT_FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx         = tx_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = bit_end ? '0 : cyc_q + CYC_ONE;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_DATA) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              idx_d   = '0;
            end
          end else begin
            idx_d   = idx_q + IDX_ONE;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Last stop bit: chain straight into the next start bit if anything is queued.
          if (idx_q == LAST_STOP) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      tx_d    = 1'b0;
      shift_d = head;
      par_d   = (PARITY == 2) ? ~^head : ^head;
      cyc_d   = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the cleared pointers make stale contents unreachable.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo across several frame formats.
// A timeline reference model per configuration predicts tx, tx_busy, fifo_count and tx_ready every cycle.
module tb_uart_tx_fifo;

  localparam int NC = 4;
  localparam int BC = 4;
  localparam int DB_A  [NC] = '{8, 8, 5, 9};
  localparam int PAR_A [NC] = '{0, 1, 2, 0};
  localparam int SB_A  [NC] = '{1, 2, 1, 2};
  localparam int DEP_A [NC] = '{4, 2, 8, 4};

  logic       clock = 1'b0;
  logic       rst;
  logic       valid_a [NC];
  logic [8:0] data_a  [NC];
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam int DB  = DB_A[g];
    localparam int PAR = PAR_A[g];
    localparam int SB  = SB_A[g];
    localparam int DEP = DEP_A[g];
    localparam int FL  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int CNW = $clog2(DEP) + 1;

    logic           tx_ready;
    logic           tx_busy;
    logic           tx;
    logic [CNW-1:0] fifo_count;

    uart_tx_fifo #(
      .CLOCK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(DB),
      .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEP)
    ) dut (
      .clock     (clock),
      .reset     (rst),
      .tx_data   (data_a[g][DB-1:0]),
      .tx_valid  (valid_a[g]),
      .tx_ready  (tx_ready),
      .fifo_count(fifo_count),
      .tx_busy   (tx_busy),
      .tx        (tx)
    );

    int q[$];
    int cur = 0;
    bit busy = 1'b0;
    int pos = 0;
    int acc_total = 0;
    int pre_n;
    bit acc;

    function automatic logic exp_line(bit b, int p, int w_i);
      int idx;
      logic [8:0] w;
      if (!b) return 1'b1;
      idx = p / BC;
      w = 9'(w_i);
      if (idx == 0) return 1'b0;
      if (idx <= DB) return w[idx-1];
      if (PAR != 0 && idx == DB + 1) return (PAR == 1) ? ^w[DB-1:0] : ~^w[DB-1:0];
      return 1'b1;
    endfunction

    always @(posedge clock or posedge rst) begin
      if (rst) begin
        q.delete();
        busy = 1'b0;
        pos  = 0;
      end else begin
        pre_n = q.size();
        acc   = valid_a[g] && (pre_n != DEP);
        if (busy) begin
          pos++;
          if (pos == FL * BC) begin
            pos = 0;
            if (pre_n > 0) cur = q.pop_front();
            else busy = 1'b0;
          end
        end else if (pre_n > 0) begin
          cur  = q.pop_front();
          busy = 1'b1;
          pos  = 0;
        end
        if (acc) begin
          q.push_back(int'(data_a[g][DB-1:0]));
          acc_total++;
        end
      end
    end

    always @(negedge clock) begin
      if (!rst) begin
        check_val($sformatf("c%0d_tx", g), 32'(tx), 32'(exp_line(busy, pos, cur)));
        check_val($sformatf("c%0d_busy", g), 32'(tx_busy), 32'(busy));
        check_val($sformatf("c%0d_count", g), 32'(fifo_count), q.size());
        check_val($sformatf("c%0d_ready", g), 32'(tx_ready), 32'(q.size() != DEP));
      end
    end
  end

  function automatic int get_acc(int g);
    case (g)
      0: return cfg[0].acc_total;
      1: return cfg[1].acc_total;
      2: return cfg[2].acc_total;
      3: return cfg[3].acc_total;
      default: return 0;
    endcase
  endfunction

  task automatic drive_all(input logic v, input logic [8:0] d);
    for (int g = 0; g < NC; g++) begin
      valid_a[g] = v;
      data_a[g]  = d;
    end
  endtask

  int busy_n, cycles, hi, low_busy;
  int base [NC];

  initial begin
    rst = 1'b1;
    drive_all(1'b0, 9'h0);
    repeat (2) @(negedge clock);
    check_val("rst_tx", 32'(cfg[0].tx), 32'd1);
    check_val("rst_busy", 32'(cfg[0].tx_busy), 32'd0);
    check_val("rst_count", 32'(cfg[0].fifo_count), 32'd0);
    check_val("rst_ready", 32'(cfg[1].tx_ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clock);

    // Single word: 0xA5 on the 8N1 channel, 0x07 on the parity channels.
    valid_a[0] = 1'b1; data_a[0] = 9'h0A5;
    valid_a[1] = 1'b1; data_a[1] = 9'h007;
    valid_a[2] = 1'b1; data_a[2] = 9'h007;
    valid_a[3] = 1'b1; data_a[3] = 9'h1A5;
    @(negedge clock);
    drive_all(1'b0, 9'h0);
    check_val("a5_pre_fall", 32'(cfg[0].tx), 32'd1);
    @(negedge clock);
    check_val("a5_fall", 32'(cfg[0].tx), 32'd0);
    busy_n = 0;
    for (int i = 0; i < 200 && cfg[0].tx_busy; i++) begin
      busy_n++;
      @(negedge clock);
    end
    check_val("a5_busy_len", busy_n, 32'd40);
    repeat (20) @(negedge clock);

    // Back-to-back 0x00 then 0xFF; measured on the 9N2 channel.
    drive_all(1'b1, 9'h000);
    @(negedge clock);
    drive_all(1'b1, 9'h0FF);
    @(negedge clock);
    drive_all(1'b0, 9'h0);
    for (int i = 0; i < 10 && cfg[3].tx; i++) @(negedge clock);
    cycles = 0; hi = 0; low_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      cycles++;
      if (!cfg[3].tx_busy) low_busy++;
      if (cfg[3].tx) hi++;
      else if (hi > 0) break;
    end
    check_val("b2b_period", cycles, 32'd48);
    check_val("b2b_stop_high", hi, 32'd8);
    check_val("b2b_busy_low", low_busy, 32'd0);
    repeat (120) @(negedge clock);

    // FIFO fill: words 1..6 held valid until accepted.
    for (int g = 0; g < NC; g++) base[g] = get_acc(g);
    for (int k = 0; k < 320; k++) begin
      if (k == 5) begin
        check_val("fill_count4", 32'(cfg[0].fifo_count), 32'd4);
        check_val("fill_ready_lo", 32'(cfg[0].tx_ready), 32'd0);
      end
      if (k == 41) check_val("fill_cnt_e40", 32'(cfg[0].fifo_count), 32'd4);
      if (k == 42) check_val("fill_cnt_pop", 32'(cfg[0].fifo_count), 32'd3);
      if (k == 43) check_val("fill_cnt_w6", 32'(cfg[0].fifo_count), 32'd4);
      for (int g = 0; g < NC; g++) begin
        valid_a[g] = (get_acc(g) - base[g]) < 6;
        data_a[g]  = 9'(get_acc(g) - base[g] + 1);
      end
      @(negedge clock);
    end
    drive_all(1'b0, 9'h0);
    repeat (60) @(negedge clock);

    // Reset during the third data bit of the first of three queued frames.
    drive_all(1'b1, 9'h011);
    @(negedge clock);
    drive_all(1'b1, 9'h022);
    @(negedge clock);
    drive_all(1'b1, 9'h033);
    @(negedge clock);
    drive_all(1'b0, 9'h0);
    repeat (12) @(negedge clock);
    rst = 1'b1;
    #1;
    check_val("mid_rst_tx", 32'(cfg[0].tx), 32'd1);
    check_val("mid_rst_busy", 32'(cfg[0].tx_busy), 32'd0);
    check_val("mid_rst_count", 32'(cfg[0].fifo_count), 32'd0);
    check_val("mid_rst_ready", 32'(cfg[0].tx_ready), 32'd1);
    @(negedge clock);
    rst = 1'b0;
    repeat (100) @(negedge clock);
    check_val("post_rst_idle", 32'(cfg[0].tx_busy), 32'd0);
    drive_all(1'b1, 9'h03C);
    @(negedge clock);
    drive_all(1'b0, 9'h0);
    repeat (60) @(negedge clock);

    // No valid while data toggles.
    for (int i = 0; i < 100; i++) begin
      for (int g = 0; g < NC; g++) begin
        valid_a[g] = 1'b0;
        data_a[g]  = 9'($urandom);
      end
      @(negedge clock);
    end
    check_val("novalid_tx", 32'(cfg[0].tx), 32'd1);
    check_val("novalid_count", 32'(cfg[2].fifo_count), 32'd0);

    // Randomized traffic, alternating heavy and sparse load.
    for (int i = 0; i < 3000; i++) begin
      for (int g = 0; g < NC; g++) begin
        if ((i / 500) % 2 == 0) valid_a[g] = ($urandom_range(0, 3) != 0);
        else valid_a[g] = ($urandom_range(0, 63) == 0);
        data_a[g] = 9'($urandom);
      end
      @(negedge clock);
    end
    drive_all(1'b0, 9'h0);
    repeat (700) @(negedge clock);
    check_val("drain_idle", 32'(cfg[1].tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
